// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes sclk/cs/mosi into the clk domain and assembles
// MSB-first N-bit words framed by an active-low chip select.
module spi_slave_rx #(
   parameter int unsigned N          = 16,
   parameter int unsigned DATA_WIDTH = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sclk,
   input  logic         cs,
   input  logic         mosi,
   output logic [N-1:0] out_data,
   output logic         data_valid,
   output logic         frame_error,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT} state_t;

   logic sclk_s1, sclk_s2, sclk_s3;
   logic cs_s1, cs_s2, cs_s3;
   // mosi is only sampled, never edge-detected, so it needs no history flop
   logic mosi_s1, mosi_s2;

   logic sclk_rise, cs_fall, cs_rise;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   // The bit that would shift out of the top is never observable, so N-1 bits suffice
   logic [N-2:0]          shift_q, shift_d;
   logic [N-1:0]          word;
   logic [N-1:0]          out_q, out_d;
   logic                  dv_q, dv_d;
   logic                  fe_q, fe_d;
   logic                  ovr_q, ovr_d;
   logic                  armed_q, armed_d;
   logic [1:0]            settle_q, settle_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_s3   <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         cs_s1   <= cs;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign cs_fall   = ~cs_s2 & cs_s3;
   assign cs_rise   = cs_s2 & ~cs_s3;
   assign word      = {shift_q, mosi_s2};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      out_d    = out_q;
      dv_d     = 1'b0;
      fe_d     = 1'b0;
      ovr_d    = ovr_q;
      settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      // After reset the cs flops hold a forced 1; a frame may only start once cs has been
      // genuinely seen high, so a frame cut by reset is ignored until cs rises and falls.
      armed_d  = armed_q | ((settle_q == 2'd3) & cs_s2 & cs_s3);

      case (state_q)
         S_IDLE: begin
            if (cs_fall && armed_q) begin
               cnt_d   = '0;
               shift_d = '0;
               ovr_d   = 1'b0;
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            if (cs_rise) begin
               fe_d    = 1'b1;
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               shift_d = word[N-2:0];
               cnt_d   = cnt_q + DATA_WIDTH'(1);
               if (cnt_q == DATA_WIDTH'(N - 1)) begin
                  out_d   = word;
                  dv_d    = 1'b1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cs_rise) begin
               fe_d    = ovr_q;
               ovr_d   = 1'b0;
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         out_q    <= '0;
         dv_q     <= 1'b0;
         fe_q     <= 1'b0;
         ovr_q    <= 1'b0;
         armed_q  <= 1'b0;
         settle_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         out_q    <= out_d;
         dv_q     <= dv_d;
         fe_q     <= fe_d;
         ovr_q    <= ovr_d;
         armed_q  <= armed_d;
         settle_q <= settle_d;
      end
   end

   assign out_data    = out_q;
   assign data_valid  = dv_q;
   assign frame_error = fe_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter N, default 16, frame/word length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 5, bit-counter width; 2^DATA_WIDTH > N required.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  serial clock from master; data sampled on its rising edge.
REQ-006 SHALL have port cs  input  1  active-low chip select framing a transfer.
REQ-007 SHALL have port mosi  input  1  serial data, MSB first.
REQ-008 SHALL have port out_data  output  N  last complete received word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when out_data updates.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse on malformed frame.
REQ-011 SHALL have port busy  output  1  high while in S_RECV or S_WAIT.

Function
REQ-012 SHALL pass sclk, cs and mosi each through a 2-flop synchronizer plus one history flop (s1, s2, s3); all decisions use s2/s3 only.
REQ-013 SHALL detect sclk rise as sclk_s2=1 and sclk_s3=0; cs fall as cs_s2=0 and cs_s3=1; cs rise as cs_s2=1 and cs_s3=0.
REQ-014 SHALL sample mosi_s2 on each detected sclk rise, shifting left into an N-bit shift register (new bit into LSB).
REQ-015 SHALL implement states S_IDLE, S_RECV, S_WAIT.
REQ-016 S_IDLE: on cs fall, clear bit counter and shift register, go to S_RECV; sclk rises ignored.
REQ-017 S_RECV: on sclk rise, shift and increment counter; on the Nth rise, load out_data with {shift[N-2:0], mosi_s2}, pulse data_valid, go to S_WAIT.
REQ-018 S_RECV: on cs rise with counter < N, pulse frame_error, discard partial word, out_data unchanged, go to S_IDLE.
REQ-019 S_WAIT: on cs rise, go to S_IDLE with no pulse; any sclk rise before that sets a sticky overrun flag; on cs rise with overrun set, pulse frame_error and clear flag.
REQ-020 Simultaneous sclk rise and cs rise in the same cycle SHALL process the cs rise only (bit dropped).
REQ-021 Latency: data_valid SHALL be high in the cycle beginning 3 clk edges after the edge on which the Nth sclk rise appears at the pin.
REQ-022 out_data SHALL hold its value between data_valid pulses; data_valid and frame_error SHALL never be high in the same cycle.
REQ-023 SHALL tolerate sclk high and low phases of one clk cycle each (master rate clk/2) without missing bits.
REQ-024 A new frame SHALL only start from S_IDLE via a cs fall; back-to-back frames with one clk of cs high SHALL be received.

Reset
REQ-025 On reset: state S_IDLE, counter 0, shift register 0, out_data 0, data_valid 0, frame_error 0, busy 0, overrun flag 0.
REQ-026 Synchronizer reset values: sclk flops 0, cs flops 1, mosi flops 0.
REQ-027 Reset mid-frame SHALL abort silently (no pulse); if cs is still low at release, the remainder of that frame SHALL be ignored until cs rises and falls again.

Verification
REQ-028 Frame 16'hA5C3, sclk at clk/2, cs low for 16 bits -> one data_valid pulse, out_data=16'hA5C3, frame_error 0, busy falls after cs rise.
REQ-029 cs low for only 8 sclk rises of 8'hFF then cs high -> frame_error pulse, no data_valid, out_data keeps prior value.
REQ-030 17 sclk rises of 16'h1234 followed by bit 1 -> data_valid with out_data=16'h1234 at 16th bit, frame_error pulse on cs rise.
REQ-031 Two frames 16'h0001 then 16'hFFFE separated by one clk of cs high -> two data_valid pulses with those values in order.
REQ-032 Assert reset after 5 bits of a frame, release with cs low, finish frame -> no data_valid or frame_error; next full frame 16'h8001 received correctly.
REQ-033 Check data_valid timing equals exactly 3 clk edges after the 16th pin-level sclk rise.
